// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write controller.
// Frame layout: {write, addr[6:0], data[7:0]}, sent MSB first.
package spi_pkg;

  localparam int SPI_FRAME_W = 16;
  localparam int SPI_ADDR_W  = 7;
  localparam int SPI_DATA_W  = 8;

  localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_GAP
  } spi_state_t;

  function automatic logic [SPI_FRAME_W-1:0] spi_frame(
    input logic                  wr,
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] data
  );
    return {wr, addr, data};
  endfunction

endpackage

// File: rtl/spi_phase_tick.sv
// SCLK phase timer: down-counter that ticks once every CLK_DIV cycles.
// Ports: clk, rst, restart (reload, suppresses tick), tick (1-cycle pulse).
module spi_phase_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  // Counter reaches zero on the last cycle of each H-cycle phase.
  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/spi_reg_writer.sv
// SPI mode-0 initiator sending one 16-bit register-write frame per request.
// Ports: clk, rst, req_valid/req_ready/req_write/req_addr/req_data,
// done (1-cycle), sclk, ncs, copi (all outputs registered).
module spi_reg_writer
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [SPI_DATA_W-1:0] req_data,
  output logic                  done,
  output logic                  sclk,
  output logic                  ncs,
  output logic                  copi
);

  spi_state_t             state;
  logic [SPI_FRAME_W-1:0] sr;
  logic [3:0]             bit_cnt;
  logic                   accept;
  logic                   tick;

  assign accept = req_valid && req_ready;

  spi_phase_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      ncs       <= 1'b1;
      sclk      <= 1'b0;
      copi      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            sr        <= spi_frame(req_write, req_addr, req_data);
            copi      <= req_write;
            bit_cnt   <= 4'd15;
            ncs       <= 1'b0;
            req_ready <= 1'b0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= ST_SCK_HI;
          end
        end
        ST_SCK_HI: begin
          if (tick) begin
            sclk    <= 1'b0;
            bit_cnt <= bit_cnt - 4'd1;
            state   <= ST_SCK_LO;
            // Last bit stays on the line through its low phase.
            if (bit_cnt != 4'd0) begin
              sr   <= sr << 1;
              copi <= sr[SPI_FRAME_W-2];
            end
          end
        end
        ST_SCK_LO: begin
          if (tick) begin
            // Counter wrapped to 15 after the 16th high phase.
            if (bit_cnt == 4'd15) begin
              ncs   <= 1'b1;
              copi  <= 1'b0;
              state <= ST_GAP;
            end else begin
              sclk  <= 1'b1;
              state <= ST_SCK_HI;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            done      <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_writer.sv
// Self-checking bench for spi_reg_writer with CLK_DIV = 4.
// Cycle-level frame model plus directed literal checks.
module tb_spi_reg_writer;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, done, sclk, ncs, copi;

  int tests = 0;
  int fails = 0;

  spi_reg_writer #(.CLK_DIV(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .done      (done),
    .sclk      (sclk),
    .ncs       (ncs),
    .copi      (copi)
  );

  always #5 clk = ~clk;

  // Model: frame accepted at cycle c0 defines all pins at c0+k.
  int          cyc = 0;
  int          c0 = 0;
  bit          busy = 0;
  bit          rdy_m = 0;
  logic [15:0] w_m = '0;

  always @(posedge clk) begin
    int k;
    bit rc;
    bit acc;
    k = cyc - c0;
    rc = busy ? (k == 34*H+1) : rdy_m;
    acc = req_valid && rc && !rst;
    if (rst) begin
      busy = 0;
      rdy_m = 0;
    end else begin
      if (acc) begin
        busy = 1;
        c0 = cyc;
        w_m = {req_write, req_addr, req_data};
      end else if (busy && k == 34*H+1) begin
        busy = 0;
      end
      rdy_m = 1;
    end
    cyc++;
  end

  // Frame monitor state
  logic [15:0] words [16];
  int          rcount [16];
  int          lowlen [16];
  int          nf = 0;
  logic [15:0] sh = '0;
  int          rises = 0;
  int          lowcnt = 0;
  int          highcnt = 0;
  int          lastgap = 0;
  int          ndone = 0;
  int          last_done_cyc = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_ncs = 1'b1;

  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] a;
    logic       b;
    int k, j, p;
    if (rst) begin
      e = 5'b10000;
    end else if (!busy) begin
      e = {4'b1000, rdy_m};
    end else begin
      k = cyc - c0;
      if (k == 34*H+1) begin
        e = 5'b10011;
      end else if (k <= H) begin
        e = {2'b00, w_m[15], 2'b00};
      end else if (k <= 33*H) begin
        j = k - H - 1;
        p = j / (2*H);
        if ((j % (2*H)) < H) begin
          b = w_m[15-p];
          e = {2'b01, b, 2'b00};
        end else begin
          b = (p == 15) ? w_m[0] : w_m[14-p];
          e = {2'b00, b, 2'b00};
        end
      end else begin
        e = 5'b10000;
      end
    end
    a = {ncs, sclk, copi, done, req_ready};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL pins cyc=%0d got=%b want=%b", cyc, a, e);
    end
    if (!ncs && sclk && !prev_sclk) begin
      sh = {sh[14:0], copi};
      rises++;
    end
    if (!ncs) lowcnt++;
    else highcnt++;
    if (ncs && !prev_ncs) begin
      words[nf] = sh;
      rcount[nf] = rises;
      lowlen[nf] = lowcnt;
      nf++;
      sh = '0;
      rises = 0;
      highcnt = 1;
    end
    if (!ncs && prev_ncs) begin
      lastgap = highcnt;
      lowcnt = 1;
    end
    if (done) begin
      ndone++;
      last_done_cyc = cyc;
    end
    prev_sclk = sclk;
    prev_ncs = ncs;
  end

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  int acc_cyc = 0;

  task automatic issue(input logic w, input logic [6:0] a,
                       input logic [7:0] d);
    int n;
    n = 0;
    req_write = w;
    req_addr = a;
    req_data = d;
    req_valid = 1'b1;
    while (!req_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 400) check("issue_timeout", n, 0);
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (ndone < target && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) check("done_timeout", ndone, target);
  endtask

  initial begin
    int base, nfb, n;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_pins", {ncs, sclk, copi, done, req_ready}, 5'b10000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("ready_low_after_rel", req_ready, 0);
    @(posedge clk); #1;
    check("ready_first_edge", req_ready, 1);

    // Single write 0x04 <- 0x80
    base = ndone;
    issue(1'b1, 7'h04, 8'h80);
    wait_done(base + 1);
    check("f1_word", words[0], 16'h8480);
    check("f1_rises", rcount[0], 16);
    check("f1_ncs_low", lowlen[0], 132);
    check("f1_done_cyc", last_done_cyc - acc_cyc, 137);
    repeat (3) @(posedge clk); #1;
    check("f1_one_done", ndone, base + 1);

    // Back-to-back with req_valid held
    base = ndone;
    req_write = 1'b1;
    req_addr = 7'h01;
    req_data = 8'hA5;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_addr = 7'h03;
    req_data = 8'h5A;
    wait_done(base + 1);
    req_valid = 1'b0;
    check("b2b_second_acc", req_ready, 0);
    wait_done(base + 2);
    check("b2b_gap", lastgap, 5);
    check("b2b_w1", words[1], 16'h81A5);
    check("b2b_w2", words[2], 16'h835A);

    // Read-flag clear: frame still sent verbatim
    base = ndone;
    issue(1'b0, 7'h00, 8'h3C);
    wait_done(base + 1);
    check("nowrite_word", words[3], 16'h003C);

    // Inputs change mid-frame; busy valid pulse ignored
    base = ndone;
    nfb = nf;
    issue(1'b1, 7'h02, 8'h11);
    repeat (20) @(posedge clk); #1;
    req_data = 8'hEE;
    req_addr = 7'h7F;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done(base + 1);
    repeat (60) @(posedge clk); #1;
    check("mid_word", words[nfb], 16'h8211);
    check("mid_frames", nf, nfb + 1);
    check("mid_dones", ndone, base + 1);

    // Reset after 6th sclk rise
    base = ndone;
    nfb = nf;
    issue(1'b1, 7'h04, 8'h55);
    n = 0;
    while (rises < 6 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 400) check("rise_timeout", rises, 6);
    #1 rst = 1'b1;
    #1;
    check("rst_pins", {ncs, sclk, copi}, 3'b100);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk); #1;
    check("rst_no_done", ndone, base);
    check("rst_partial", rcount[nfb], 6);

    // Normal frame after abort
    base = ndone;
    issue(1'b1, 7'h03, 8'hC3);
    wait_done(base + 1);
    check("post_rst_word", words[nfb+1], 16'h83C3);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
